// File: rtl/phy_tx_lane_serializer.sv
// phy_tx_lane_serializer: stripes one symbol stream round-robin over LANES lanes, MSB-first per lane.
// Symbols staged during a frame go out together in the next frame; lanes without data send IDLE_SYM.
module phy_tx_lane_serializer #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC
) (
    input  logic                         clk_8f,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic [$clog2(LANES+1)-1:0]   cfg_lanes,
    output logic [LANES-1:0]             serial_out,
    output logic [LANES-1:0]             lane_valid,
    output logic                         frame_start
);
    localparam int CW = $clog2(LANES+1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    fill, active, cfg_sane;
    logic [WIDTH-1:0] slot [LANES];
    logic [LANES-1:0] slot_v;
    logic [WIDTH-1:0] shreg [LANES];
    logic             boundary, accept;

    assign boundary  = bit_cnt == BW'(WIDTH-1);
    assign ready_out = fill < active;
    assign accept    = valid_in && ready_out;
    assign cfg_sane  = (cfg_lanes == '0 || cfg_lanes > CW'(LANES)) ? CW'(LANES) : cfg_lanes;

    always_comb begin
        serial_out = '0;
        for (int i = 0; i < LANES; i++) serial_out[i] = shreg[i][WIDTH-1];
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            fill        <= '0;
            slot_v      <= '0;
            active      <= CW'(LANES);
            frame_start <= 1'b1;
            lane_valid  <= '0;
            for (int i = 0; i < LANES; i++) begin
                shreg[i] <= IDLE_SYM;
                slot[i]  <= '0;
            end
        end else begin
            bit_cnt     <= boundary ? '0 : bit_cnt + BW'(1);
            frame_start <= boundary;
            if (boundary) begin
                fill   <= '0;
                slot_v <= '0;
                active <= cfg_sane;
                // a symbol accepted in the boundary cycle bypasses its slot straight into the shifter
                for (int i = 0; i < LANES; i++) begin
                    shreg[i]      <= slot_v[i] ? slot[i] :
                                     (accept && fill == CW'(i)) ? data_in : IDLE_SYM;
                    lane_valid[i] <= slot_v[i] || (accept && fill == CW'(i));
                end
            end else begin
                if (accept) fill <= fill + CW'(1);
                for (int i = 0; i < LANES; i++) begin
                    shreg[i] <= shreg[i] << 1;
                    if (accept && fill == CW'(i)) begin
                        slot[i]   <= data_in;
                        slot_v[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// tb_phy_tx_lane_serializer: directed and random stimulus against a frame-level queue model.
// The model collects each frame's accepted symbols and indexes bits of the symbols on air.
module tb_phy_tx_lane_serializer;
    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] IDLE = 8'hBC;
    localparam int CW = $clog2(LANES+1);

    logic             clk_8f = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic [CW-1:0]    cfg_lanes;
    logic [LANES-1:0] serial_out;
    logic [LANES-1:0] lane_valid;
    logic             frame_start;

    phy_tx_lane_serializer #(.LANES(LANES), .WIDTH(WIDTH), .IDLE_SYM(IDLE)) dut (
        .clk_8f(clk_8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .cfg_lanes(cfg_lanes), .serial_out(serial_out),
        .lane_valid(lane_valid), .frame_start(frame_start)
    );

    always #5 clk_8f = ~clk_8f;

    int cmp = 0;
    int mis = 0;
    int pos;
    int active_m;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] src[$];
    logic [WIDTH-1:0] cur_sym [LANES];
    logic [LANES-1:0] cur_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h (pos %0d)", tag, obs, exp, pos);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        active_m = LANES;
        q.delete();
        cur_v = '0;
        for (int l = 0; l < LANES; l++) cur_sym[l] = IDLE;
    endtask

    task automatic check_outputs();
        logic [LANES-1:0] es;
        for (int l = 0; l < LANES; l++) es[l] = cur_sym[l][WIDTH-1-pos];
        chk("serial_out", 64'(serial_out), 64'(es));
        chk("lane_valid", 64'(lane_valid), 64'(cur_v));
        chk("ready_out", 64'(ready_out), 64'(q.size() < active_m));
        chk("frame_start", 64'(frame_start), 64'(pos == 0));
    endtask

    task automatic step();
        logic rdy;
        rdy = q.size() < active_m;
        check_outputs();
        valid_in = src.size() != 0;
        data_in = valid_in ? src[0] : WIDTH'($urandom);
        @(posedge clk_8f);
        if (valid_in && rdy) begin
            q.push_back(data_in);
            void'(src.pop_front());
        end
        if (pos == WIDTH-1) begin
            for (int l = 0; l < LANES; l++) begin
                cur_v[l] = l < q.size();
                cur_sym[l] = cur_v[l] ? q[l] : IDLE;
            end
            q.delete();
            active_m = (cfg_lanes >= 1 && cfg_lanes <= LANES) ? int'(cfg_lanes) : LANES;
        end
        pos = (pos + 1) % WIDTH;
        @(negedge clk_8f);
    endtask

    task automatic wait_pos(input int p);
        while (pos != p) step();
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        cfg_lanes = '0;
        model_reset();
        repeat (2) @(negedge clk_8f);
        reset = 1'b0;
        repeat (3 * WIDTH) step();
        // full-rate stream, ready drops after each group of four
        cfg_lanes = 3'd4;
        for (int i = 1; i <= 8; i++) src.push_back(WIDTH'(i));
        repeat (3 * WIDTH) step();
        // single symbols in consecutive frames both land on lane 0
        wait_pos(3);
        src.push_back(8'hA5);
        wait_pos(2);
        src.push_back(8'h5A);
        repeat (2 * WIDTH) step();
        // width change mid-frame takes effect at the boundary
        wait_pos(2);
        cfg_lanes = 3'd2;
        src.push_back(8'h11);
        src.push_back(8'h22);
        src.push_back(8'h33);
        repeat (3 * WIDTH) step();
        cfg_lanes = '0;
        repeat (WIDTH) step();
        // accept exactly in the boundary cycle; a data symbol equal to IDLE
        wait_pos(WIDTH-1);
        src.push_back(8'hC3);
        step();
        src.push_back(IDLE);
        repeat (2 * WIDTH) step();
        // async reset with data shifting and three symbols staged
        wait_pos(0);
        for (int i = 0; i < 4; i++) src.push_back(8'hE1 + WIDTH'(i));
        wait_pos(WIDTH-1);
        step();
        src.push_back(8'hD1);
        src.push_back(8'hD2);
        src.push_back(8'hD3);
        repeat (4) step();
        #2 reset = 1'b1;
        model_reset();
        src.delete();
        valid_in = 1'b0;
        #1 check_outputs();
        @(negedge clk_8f);
        reset = 1'b0;
        repeat (3 * WIDTH) step();
        // random traffic with random width changes, including 0 and >LANES
        repeat (400) begin
            if ($urandom_range(9) == 0) cfg_lanes = CW'($urandom_range(7));
            if (src.size() < 4 && $urandom_range(2) != 0) src.push_back(WIDTH'($urandom));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
